// File: rtl/srd_lane_rst_rel.sv
// Lane TX/RX reset release sequencer downstream of the SerDes reset handshake.
// Releases TX then RX, watches ready, and re-arms upstream on timeout or loss of ready.
module srd_lane_rst_rel #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_srd_rst_done,
  input  logic       i_tx_ready,
  input  logic       i_rx_ready,
  input  logic       i_restart,
  output logic       o_srd_rst_n,
  output logic       o_tx_rst,
  output logic       o_rx_rst,
  output logic       o_ready,
  output logic       o_fail,
  output logic [7:0] o_retry_total
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TX_REL = 3'd1,
    S_RX_REL = 3'd2,
    S_READY  = 3'd3,
    S_REQ    = 3'd4,
    S_DRAIN  = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            tx_rst_q, tx_rst_d;
  logic            rx_rst_q, rx_rst_d;
  logic            ready_q, ready_d;
  logic            srd_rst_n_q, srd_rst_n_d;
  logic            fail_q, fail_d;
  logic [7:0]      total_q, total_d;
  logic [7:0]      total_inc;
  logic            timeout;
  logic            fail_evt;
  logic            go_idle;

  assign total_inc = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
  assign timeout   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    tx_rst_d    = tx_rst_q;
    rx_rst_d    = rx_rst_q;
    ready_d     = ready_q;
    srd_rst_n_d = srd_rst_n_q;
    fail_d      = fail_q;
    total_d     = total_q;
    fail_evt    = 1'b0;
    go_idle     = 1'b0;

    if (i_restart && state_q != S_REQ && state_q != S_DRAIN) begin
      state_d     = S_REQ;
      retry_d     = '0;
      fail_d      = 1'b0;
      total_d     = total_inc;
      tx_rst_d    = 1'b1;
      rx_rst_d    = 1'b1;
      ready_d     = 1'b0;
      srd_rst_n_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_rst_d = 1'b1;
          rx_rst_d = 1'b1;
          ready_d  = 1'b0;
          if (i_srd_rst_done) begin
            state_d  = S_TX_REL;
            tx_rst_d = 1'b0;
            cnt_d    = '0;
          end
        end
        S_TX_REL: begin
          if (!i_srd_rst_done) begin
            go_idle = 1'b1;
          end else if (i_tx_ready) begin
            state_d  = S_RX_REL;
            rx_rst_d = 1'b0;
            cnt_d    = '0;
          end else if (timeout) begin
            fail_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // Losing TX ready while waiting on RX outranks RX success.
        S_RX_REL: begin
          if (!i_srd_rst_done) begin
            go_idle = 1'b1;
          end else if (!i_tx_ready) begin
            fail_evt = 1'b1;
          end else if (i_rx_ready) begin
            state_d = S_READY;
            ready_d = 1'b1;
            retry_d = '0;
          end else if (timeout) begin
            fail_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_READY: begin
          if (!i_srd_rst_done) begin
            go_idle = 1'b1;
          end else if (!i_tx_ready || !i_rx_ready) begin
            fail_evt = 1'b1;
          end
        end
        S_REQ: begin
          srd_rst_n_d = 1'b0;
          state_d     = S_DRAIN;
        end
        S_DRAIN: begin
          srd_rst_n_d = 1'b1;
          if (!i_srd_rst_done) begin
            state_d = S_IDLE;
          end
        end
        S_FAIL: begin
          tx_rst_d = 1'b1;
          rx_rst_d = 1'b1;
          ready_d  = 1'b0;
          fail_d   = 1'b1;
        end
        default: begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          retry_d     = '0;
          tx_rst_d    = 1'b1;
          rx_rst_d    = 1'b1;
          ready_d     = 1'b0;
          srd_rst_n_d = 1'b1;
        end
      endcase
    end

    if (go_idle) begin
      state_d  = S_IDLE;
      tx_rst_d = 1'b1;
      rx_rst_d = 1'b1;
      ready_d  = 1'b0;
    end

    if (fail_evt) begin
      tx_rst_d = 1'b1;
      rx_rst_d = 1'b1;
      ready_d  = 1'b0;
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = S_REQ;
        retry_d = retry_q + RW'(1);
        total_d = total_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      tx_rst_q    <= 1'b1;
      rx_rst_q    <= 1'b1;
      ready_q     <= 1'b0;
      srd_rst_n_q <= 1'b1;
      fail_q      <= 1'b0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      tx_rst_q    <= tx_rst_d;
      rx_rst_q    <= rx_rst_d;
      ready_q     <= ready_d;
      srd_rst_n_q <= srd_rst_n_d;
      fail_q      <= fail_d;
      total_q     <= total_d;
    end
  end

  assign o_srd_rst_n   = srd_rst_n_q;
  assign o_tx_rst      = tx_rst_q;
  assign o_rx_rst      = rx_rst_q;
  assign o_ready       = ready_q;
  assign o_fail        = fail_q;
  assign o_retry_total = total_q;

endmodule

// File: doc/srd_lane_rst_rel.md
# srd_lane_rst_rel

Downstream companion to the SerDes reset request/acknowledge sequencer. Once the SerDes reset handshake reports done, this block releases the lane TX reset, then the RX reset, and waits for each side's ready. On a timeout or a loss of ready it re-arms the upstream sequencer with a one-cycle active-low request pulse, up to a bounded retry count. It sits between the reset sequencer and the MAC/PCS lane logic and produces the single "lane usable" indication.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for tx_ready or rx_ready after each release (≥2)
- MAX_RETRY, 3: consecutive retries allowed before declaring failure (≥1)

Ports:
- i_clk  in  1  sole clock; all inputs synchronous to it (ready inputs arrive pre-synchronized)
- i_rst  in  1  synchronous, active-high reset
- i_srd_rst_done  in  1  done from upstream SerDes reset sequencer
- i_tx_ready  in  1  lane TX ready
- i_rx_ready  in  1  lane RX ready
- i_restart  in  1  one-cycle pulse; software-forced restart, clears failure
- o_srd_rst_n  out  1  reset request to upstream sequencer; idles 1, pulses 0 for exactly one cycle
- o_tx_rst  out  1  lane TX reset, active-high
- o_rx_rst  out  1  lane RX reset, active-high
- o_ready  out  1  lane fully out of reset and ready
- o_fail  out  1  sticky; retries exhausted
- o_retry_total  out  8  saturating count of requests issued since i_rst

## Operation
- All outputs registered. On i_rst: state IDLE, o_tx_rst=1, o_rx_rst=1, o_ready=0, o_srd_rst_n=1, o_fail=0, o_retry_total=0, timeout counter=0, retry_cnt=0.
- Internal timeout counter width is $clog2(TIMEOUT_CYCLES+1). Internal retry_cnt width is $clog2(MAX_RETRY+1).
- "Failure event" handling:
  - If retry_cnt==MAX_RETRY: go to FAIL and set o_fail=1.
  - Otherwise: go to REQ, increment retry_cnt, and increment o_retry_total (saturating at 255).
  - In both cases drive o_tx_rst=1, o_rx_rst=1, o_ready=0.
- IDLE:
  - Both resets are held.
  - When i_srd_rst_done=1: go to TX_REL, set o_tx_rst<=0, clear the counter.
- TX_REL:
  - The counter increments each cycle.
  - If i_tx_ready=1: go to RX_REL, set o_rx_rst<=0, clear the counter.
  - Else if the counter reaches TIMEOUT_CYCLES-1: failure event.
  - If i_srd_rst_done=0: go to IDLE with both resets asserted (no retry counted).
- RX_REL:
  - Same as TX_REL, with i_rx_ready as the condition.
  - On success: go to READY, set o_ready<=1, clear retry_cnt.
  - If i_tx_ready drops: failure event.
- READY:
  - If i_srd_rst_done=0: go to IDLE, resets<=1, o_ready<=0, no retry counted.
  - Else if i_tx_ready=0 or i_rx_ready=0: failure event.
- REQ: set o_srd_rst_n<=0 for this one cycle and go to DRAIN.
- DRAIN:
  - o_srd_rst_n<=1.
  - Wait for i_srd_rst_done=0, then go to IDLE.
  - No timeout in DRAIN.
- FAIL: resets are held and o_fail=1. Exit only via i_restart or i_rst.
- i_restart:
  - In any state except REQ/DRAIN: go to REQ, retry_cnt<=0, o_fail<=0, o_retry_total incremented. Resets are asserted.
  - In REQ/DRAIN: ignored.
  - Takes priority over all other transitions in the same cycle.
- Simultaneous events in TX_REL/RX_REL: an i_srd_rst_done drop wins over ready or timeout.
- Invalid state encoding: return to IDLE with reset values, except o_fail and o_retry_total, which are held.

## Timing
- Input sampled at edge N → state and outputs change after edge N (one-cycle registered latency).
- Nominal path: i_srd_rst_done rises before edge N → o_tx_rst=0 from N+1.
- Ready inputs: i_tx_ready=1 at edge M → o_rx_rst=0 from M+1. i_rx_ready=1 at edge K → o_ready=1 from K+1.
- Timeout: fires at the edge where counter==TIMEOUT_CYCLES-1, which is TIMEOUT_CYCLES cycles after the release edge. The resets re-assert on the next cycle, followed by one cycle of o_srd_rst_n=0.
- o_srd_rst_n low width is exactly 1 cycle, and it is always preceded by ≥1 cycle of resets asserted.
- Upstream drops done about 2 cycles after the pulse; DRAIN tolerates any delay.

## Test plan
- Nominal: TIMEOUT_CYCLES=16. Drive done=1; tx_ready 3 cycles after tx release; rx_ready 5 cycles after rx release. Expect o_tx_rst falling, o_rx_rst falling, and o_ready rising each 1 cycle after its trigger. o_srd_rst_n stays 1; o_retry_total=0.
- TX timeout: tx_ready held 0. Expect exactly 16 cycles with tx released, then resets=1, one o_srd_rst_n=0 cycle, and o_retry_total=1. Model done dropping; expect the sequence to restart.
- Exhaustion: MAX_RETRY=3, tx_ready never rises. Expect 3 request pulses, then o_fail=1 with resets held and no 4th pulse. Then pulse i_restart: expect o_fail=0, one request pulse, o_retry_total=4.
- Link loss: in READY, drop rx_ready for 1 cycle. Expect o_ready=0 and resets=1 the next cycle, one request pulse, and retry_cnt cleared on the next successful READY.
- Upstream rerun: in READY, drop done. Expect IDLE with resets asserted, no request pulse, and o_retry_total unchanged.
- Mid-operation reset: assert i_rst for 1 cycle in RX_REL and during REQ. Expect every output at its reset value the next cycle, and o_srd_rst_n=1.
